led_scan_sched: RTL

//  Sequencer for the 3-to-8 active-low LED decoder (lights led[switch] only when enable==3'b100).

---
 rtl/led_scan_sched_if.sv | 27 ++
 rtl/led_scan_sched.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/led_scan_sched_if.sv
// Control/decoder bundle for led_scan_sched: the control side is the master,
// the sequencer is the slave and drives the decoder and status lines.
interface led_scan_sched_if #(
    parameter int DWELL_W = 8
);
    logic               start;
    logic               stop;
    logic [7:0]         mask;
    logic [DWELL_W-1:0] dwell;
    logic               manual_req;
    logic [2:0]         manual_sel;
    logic               manual_gnt;
    logic [2:0]         switch;
    logic [2:0]         enable;
    logic               busy;
    logic               cycle_done;

    modport master (
        output start, stop, mask, dwell, manual_req, manual_sel,
        input  manual_gnt, switch, enable, busy, cycle_done
    );

    modport slave (
        input  start, stop, mask, dwell, manual_req, manual_sel,
        output manual_gnt, switch, enable, busy, cycle_done
    );
endinterface

// File: rtl/led_scan_sched.sv
// Round-robin LED decoder sequencer with manual-requester arbitration.
// Define SCAN_BLANK_EN to insert one blank SEEK cycle between lit channels.
module led_scan_sched #(
    parameter int DWELL_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    led_scan_sched_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SEEK, HOLD, MANUAL} state_t;

    state_t             state;
    state_t             seek_state;
    logic [2:0]         ptr;
    logic [2:0]         nxt;
    logic [DWELL_W-1:0] cnt;
    logic [DWELL_W-1:0] cnt_load;
    logic               first;
    logic               owed;
    logic               first_eff;
    logic               seek_owed;
    logic               start_ok;
    logic               hold_done;
    logic               do_seek;

    assign start_ok  = bus.start && (bus.mask != 8'h00);
    assign cnt_load  = (bus.dwell == '0) ? DWELL_W'(1) : bus.dwell;
    assign hold_done = (state == HOLD) && (cnt == DWELL_W'(1));
    // A direct start from IDLE always counts as the first visit.
    assign first_eff = first || (state == IDLE);
    // Leaving MANUAL always owes a scan channel; finishing a dwell pays it off.
    assign seek_owed = (state == MANUAL) ? 1'b1 : ((state == HOLD) ? 1'b0 : owed);

    always_comb begin
        nxt = ptr;
        for (int k = 8; k >= 1; k--) begin
            if (bus.mask[ptr + 3'(k)]) nxt = ptr + 3'(k);
        end
    end

    always_comb begin
        seek_state = HOLD;
        if (bus.mask == 8'h00)                    seek_state = IDLE;
        else if (bus.manual_req && !seek_owed)    seek_state = MANUAL;
    end

`ifdef SCAN_BLANK_EN
    assign do_seek = (state == SEEK);
`else
    // Without the blank cycle the boundary decision is made at the expiry edge.
    assign do_seek = hold_done
                  || ((state == MANUAL) && !bus.manual_req && bus.busy)
                  || ((state == IDLE) && !bus.manual_req && start_ok);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            ptr            <= 3'd7;
            cnt            <= '0;
            first          <= 1'b1;
            owed           <= 1'b0;
            bus.switch     <= 3'b000;
            bus.enable     <= 3'b000;
            bus.manual_gnt <= 1'b0;
            bus.busy       <= 1'b0;
            bus.cycle_done <= 1'b0;
        end else begin
            bus.cycle_done <= 1'b0;
            if (bus.stop) begin
                state          <= IDLE;
                bus.enable     <= 3'b000;
                bus.manual_gnt <= 1'b0;
                bus.busy       <= 1'b0;
                owed           <= 1'b0;
            end else if (do_seek) begin
                if (state == IDLE) begin
                    bus.busy <= 1'b1;
                    first    <= 1'b1;
                end
                if (state == HOLD)   owed <= 1'b0;
                if (state == MANUAL) owed <= 1'b1;
                case (seek_state)
                    IDLE: begin
                        state          <= IDLE;
                        bus.busy       <= 1'b0;
                        owed           <= 1'b0;
                        bus.enable     <= 3'b000;
                        bus.manual_gnt <= 1'b0;
                    end
                    MANUAL: begin
                        state          <= MANUAL;
                        bus.manual_gnt <= 1'b1;
                        bus.enable     <= 3'b100;
                        bus.switch     <= bus.manual_sel;
                    end
                    default: begin
                        state          <= HOLD;
                        ptr            <= nxt;
                        cnt            <= cnt_load;
                        first          <= 1'b0;
                        bus.switch     <= nxt;
                        bus.enable     <= 3'b100;
                        bus.manual_gnt <= 1'b0;
                        bus.cycle_done <= (nxt <= ptr) && !first_eff;
                    end
                endcase
            end else begin
                case (state)
                    IDLE: begin
                        owed <= 1'b0;
                        if (bus.manual_req) begin
                            state          <= MANUAL;
                            bus.manual_gnt <= 1'b1;
                            bus.enable     <= 3'b100;
                            bus.switch     <= bus.manual_sel;
                            if (start_ok) begin
                                bus.busy <= 1'b1;
                                first    <= 1'b1;
                            end
                        end else if (start_ok) begin
                            state    <= SEEK;
                            bus.busy <= 1'b1;
                            first    <= 1'b1;
                        end
                    end
                    HOLD: begin
                        if (hold_done) begin
                            state      <= SEEK;
                            owed       <= 1'b0;
                            bus.enable <= 3'b000;
                        end else begin
                            cnt <= cnt - DWELL_W'(1);
                        end
                    end
                    MANUAL: begin
                        if (bus.manual_req) begin
                            bus.switch <= bus.manual_sel;
                        end else begin
                            bus.manual_gnt <= 1'b0;
                            bus.enable     <= 3'b000;
                            if (bus.busy) begin
                                state <= SEEK;
                                owed  <= 1'b1;
                            end else begin
                                state <= IDLE;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
